// File: rtl/substantivo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | substantivo_pkg                                                    |
// | Shared types and default codes for the noun classifier.            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package substantivo_pkg;

   // FSM state, visible on the estado output
   typedef enum logic [2:0] {
      ST_INICIO   = 3'd0,
      ST_CONCRETO = 3'd1,
      ST_ABSTRATO = 3'd2,
      ST_NOMEP    = 3'd3,
      ST_FIM      = 3'd4
   } estado_t;

   // Noun class, shared by tipo and maioria
   typedef enum logic [1:0] {
      TIPO_NENHUM   = 2'b00,
      TIPO_CONCRETO = 2'b01,
      TIPO_ABSTRATO = 2'b10,
      TIPO_NOMEP    = 2'b11
   } tipo_t;

   // Result of decoding one input code
   typedef enum logic [2:0] {
      DEC_CONCRETO = 3'd0,
      DEC_ABSTRATO = 3'd1,
      DEC_NOMEP    = 3'd2,
      DEC_FIM      = 3'd3,
      DEC_INVALIDO = 3'd4
   } decode_t;

   localparam int C_COD_CONCRETO = 7;
   localparam int C_COD_ABSTRATO = 9;
   localparam int C_COD_NOMEP    = 10;
   localparam int C_COD_FIM0     = 0;
   localparam int C_COD_FIM1     = 1;

endpackage
`default_nettype wire

// File: rtl/sincroniza_borda.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sincroniza_borda                                                   |
// | Two-flop synchroniser for an asynchronous key plus a one-clock     |
// | pulse on its rising edge.                                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sincroniza_borda (
   input  logic clock,
   input  logic reset,
   input  logic entrada,
   output logic pulso
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Two metastability flops followed by a delay flop for edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= entrada;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign pulso = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/classificador_substantivos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | classificador_substantivos                                         |
// | Classifies strobed noun codes, keeps saturating per-class counts   |
// | and reports the majority class when a sentence is closed.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module classificador_substantivos
   import substantivo_pkg::*;
#(
   parameter int NOTA_W       = 5,
   parameter int CONT_W       = 8,
   parameter int COD_CONCRETO = C_COD_CONCRETO,
   parameter int COD_ABSTRATO = C_COD_ABSTRATO,
   parameter int COD_NOMEP    = C_COD_NOMEP,
   parameter int COD_FIM0     = C_COD_FIM0,
   parameter int COD_FIM1     = C_COD_FIM1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ok,
   input  logic [NOTA_W-1:0] nota,
   output logic [2:0]        estado,
   output logic [1:0]        tipo,
   output logic              fim,
   output logic [1:0]        maioria,
   output logic              erro,
   output logic [CONT_W-1:0] cont_concreto,
   output logic [CONT_W-1:0] cont_abstrato,
   output logic [CONT_W-1:0] cont_nomep
);

   logic              w_ok_p;
   decode_t           w_dec;
   estado_t           r_estado, w_estado_n;
   tipo_t             r_tipo, w_tipo_n;
   tipo_t             r_maioria, w_maioria_n;
   logic              r_erro, w_erro_n;
   logic [CONT_W-1:0] r_cc, r_ca, r_cn;
   logic [CONT_W-1:0] w_cc_n, w_ca_n, w_cn_n;

   sincroniza_borda u_sincroniza_ok (
      .clock   (clock),
      .reset   (reset),
      .entrada (ok),
      .pulso   (w_ok_p)
   );

   // Counters stop at all-ones instead of wrapping
   function automatic logic [CONT_W-1:0] sat_inc(input logic [CONT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Largest count wins; ties go to the later class in nomep > abstrato > concreto
   function automatic tipo_t majoritaria(input logic [CONT_W-1:0] c,
                                         input logic [CONT_W-1:0] a,
                                         input logic [CONT_W-1:0] n);
      if ((c | a | n) == '0)
         return TIPO_NENHUM;
      else if (n >= a && n >= c)
         return TIPO_NOMEP;
      else if (a >= c)
         return TIPO_ABSTRATO;
      else
         return TIPO_CONCRETO;
   endfunction

   // Decode the sampled code; noun codes take precedence if a code is shared
   always_comb begin
      w_dec = DEC_INVALIDO;
      if (nota == NOTA_W'(COD_CONCRETO))
         w_dec = DEC_CONCRETO;
      else if (nota == NOTA_W'(COD_ABSTRATO))
         w_dec = DEC_ABSTRATO;
      else if (nota == NOTA_W'(COD_NOMEP))
         w_dec = DEC_NOMEP;
      else if (nota == NOTA_W'(COD_FIM0) || nota == NOTA_W'(COD_FIM1))
         w_dec = DEC_FIM;
   end

   // State, class, majority, error and counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado  <= ST_INICIO;
         r_tipo    <= TIPO_NENHUM;
         r_maioria <= TIPO_NENHUM;
         r_erro    <= 1'b0;
         r_cc      <= '0;
         r_ca      <= '0;
         r_cn      <= '0;
      end else begin
         r_estado  <= w_estado_n;
         r_tipo    <= w_tipo_n;
         r_maioria <= w_maioria_n;
         r_erro    <= w_erro_n;
         r_cc      <= w_cc_n;
         r_ca      <= w_ca_n;
         r_cn      <= w_cn_n;
      end
   end

   // Next-state logic; nothing moves except on a confirmed key pulse
   always_comb begin
      w_estado_n  = r_estado;
      w_tipo_n    = r_tipo;
      w_maioria_n = r_maioria;
      w_erro_n    = 1'b0;
      w_cc_n      = r_cc;
      w_ca_n      = r_ca;
      w_cn_n      = r_cn;
      if (w_ok_p) begin
         case (w_dec)
            DEC_CONCRETO, DEC_ABSTRATO, DEC_NOMEP: begin
               // A noun after a closed sentence starts a fresh one
               if (r_estado == ST_FIM) begin
                  w_cc_n      = '0;
                  w_ca_n      = '0;
                  w_cn_n      = '0;
                  w_maioria_n = TIPO_NENHUM;
               end
               case (w_dec)
                  DEC_CONCRETO: begin
                     w_cc_n     = sat_inc(w_cc_n);
                     w_estado_n = ST_CONCRETO;
                     w_tipo_n   = TIPO_CONCRETO;
                  end
                  DEC_ABSTRATO: begin
                     w_ca_n     = sat_inc(w_ca_n);
                     w_estado_n = ST_ABSTRATO;
                     w_tipo_n   = TIPO_ABSTRATO;
                  end
                  default: begin
                     w_cn_n     = sat_inc(w_cn_n);
                     w_estado_n = ST_NOMEP;
                     w_tipo_n   = TIPO_NOMEP;
                  end
               endcase
            end
            DEC_FIM: begin
               // A repeated end code leaves the closed sentence untouched
               if (r_estado != ST_FIM) begin
                  w_estado_n  = ST_FIM;
                  w_maioria_n = majoritaria(r_cc, r_ca, r_cn);
               end
            end
            default: w_erro_n = 1'b1;
         endcase
      end
   end

   assign estado        = r_estado;
   assign tipo          = r_tipo;
   assign fim           = (r_estado == ST_FIM);
   assign maioria       = r_maioria;
   assign erro          = r_erro;
   assign cont_concreto = r_cc;
   assign cont_abstrato = r_ca;
   assign cont_nomep    = r_cn;

endmodule
`default_nettype wire

// File: tb/tb_classificador_substantivos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_classificador_substantivos                                      |
// | Scoreboard bench: one instance with default widths and one with    |
// | 2-bit counters share the same key/code stimulus.                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_classificador_substantivos;

   logic       clock;
   logic       reset;
   logic       ok;
   logic [4:0] nota;

   logic [2:0] e1_estado, e2_estado;
   logic [1:0] e1_tipo, e2_tipo, e1_maioria, e2_maioria;
   logic       e1_fim, e2_fim, e1_erro, e2_erro;
   logic [7:0] e1_cc, e1_ca, e1_cn;
   logic [1:0] e2_cc, e2_ca, e2_cn;

   int testes = 0;
   int falhas = 0;

   typedef struct {
      int st; int tp; int mj; int cc; int ca; int cn; int er;
   } modelo_t;

   typedef struct {
      modelo_t m1;
      modelo_t m2;
      string   nome;
   } esperado_t;

   modelo_t   mod1, mod2;
   esperado_t fila[$];

   classificador_substantivos dut (
      .clock(clock), .reset(reset), .ok(ok), .nota(nota),
      .estado(e1_estado), .tipo(e1_tipo), .fim(e1_fim), .maioria(e1_maioria),
      .erro(e1_erro), .cont_concreto(e1_cc), .cont_abstrato(e1_ca), .cont_nomep(e1_cn)
   );

   classificador_substantivos #(.CONT_W(2)) dut2 (
      .clock(clock), .reset(reset), .ok(ok), .nota(nota),
      .estado(e2_estado), .tipo(e2_tipo), .fim(e2_fim), .maioria(e2_maioria),
      .erro(e2_erro), .cont_concreto(e2_cc), .cont_abstrato(e2_ca), .cont_nomep(e2_cn)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic verifica(input string tag, input int obs, input int esp);
      testes++;
      if (obs != esp) begin
         falhas++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
      end
   endtask

   function automatic modelo_t zera();
      modelo_t z;
      z.st = 0; z.tp = 0; z.mj = 0; z.cc = 0; z.ca = 0; z.cn = 0; z.er = 0;
      return z;
   endfunction

   // Scan classes in ascending priority; >= lets the later class win a tie
   function automatic int maj(input modelo_t m);
      int melhor = 0;
      int valor  = 0;
      int cnt[3];
      cnt[0] = m.cc; cnt[1] = m.ca; cnt[2] = m.cn;
      for (int k = 0; k < 3; k++)
         if (cnt[k] > 0 && cnt[k] >= valor) begin
            melhor = k + 1;
            valor  = cnt[k];
         end
      return melhor;
   endfunction

   function automatic modelo_t passo(input modelo_t m, input int code, input int maxc);
      modelo_t r;
      int k;
      r = m;
      r.er = 0;
      if (code == 7) k = 1;
      else if (code == 9) k = 2;
      else if (code == 10) k = 3;
      else if (code == 0 || code == 1) k = 4;
      else k = 0;
      if (k >= 1 && k <= 3) begin
         if (r.st == 4) begin
            r.cc = 0; r.ca = 0; r.cn = 0; r.mj = 0;
         end
         if (k == 1 && r.cc < maxc) r.cc++;
         if (k == 2 && r.ca < maxc) r.ca++;
         if (k == 3 && r.cn < maxc) r.cn++;
         r.st = k;
         r.tp = k;
      end else if (k == 4) begin
         if (r.st != 4) begin
            r.mj = maj(r);
            r.st = 4;
         end
      end else begin
         r.er = 1;
      end
      return r;
   endfunction

   task automatic compara(input esperado_t e, input int er1, input int er2);
      verifica({e.nome, " estado"},  int'(e1_estado),  e.m1.st);
      verifica({e.nome, " tipo"},    int'(e1_tipo),    e.m1.tp);
      verifica({e.nome, " fim"},     int'(e1_fim),     (e.m1.st == 4) ? 1 : 0);
      verifica({e.nome, " maioria"}, int'(e1_maioria), e.m1.mj);
      verifica({e.nome, " cc"},      int'(e1_cc),      e.m1.cc);
      verifica({e.nome, " ca"},      int'(e1_ca),      e.m1.ca);
      verifica({e.nome, " cn"},      int'(e1_cn),      e.m1.cn);
      verifica({e.nome, " erro"},    er1,              e.m1.er);
      verifica({e.nome, " w2 estado"},  int'(e2_estado),  e.m2.st);
      verifica({e.nome, " w2 maioria"}, int'(e2_maioria), e.m2.mj);
      verifica({e.nome, " w2 cc"},      int'(e2_cc),      e.m2.cc);
      verifica({e.nome, " w2 ca"},      int'(e2_ca),      e.m2.ca);
      verifica({e.nome, " w2 cn"},      int'(e2_cn),      e.m2.cn);
      verifica({e.nome, " w2 erro"},    er2,              e.m2.er);
   endtask

   // Hold ok high for 'hold' clocks (optionally changing nota after it has been taken),
   // then release it; erro pulses are counted over the whole strobe window.
   task automatic strobe(input int code, input int hold, input int troca, input string nome);
      esperado_t e;
      int er1 = 0;
      int er2 = 0;
      @(negedge clock);
      nota = 5'(code);
      ok   = 1'b1;
      mod1 = passo(mod1, code, 255);
      mod2 = passo(mod2, code, 3);
      e.m1 = mod1; e.m2 = mod2; e.nome = nome;
      fila.push_back(e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (e1_erro) er1++;
         if (e2_erro) er2++;
         if (i == 5 && troca >= 0) nota = 5'(troca);
      end
      ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (e1_erro) er1++;
         if (e2_erro) er2++;
      end
      if (fila.size() == 0)
         verifica({nome, " scoreboard empty"}, 0, 1);
      else
         compara(fila.pop_front(), er1, er2);
   endtask

   task automatic verifica_reset(input string nome);
      verifica({nome, " estado"},  int'(e1_estado),  0);
      verifica({nome, " tipo"},    int'(e1_tipo),    0);
      verifica({nome, " fim"},     int'(e1_fim),     0);
      verifica({nome, " maioria"}, int'(e1_maioria), 0);
      verifica({nome, " erro"},    int'(e1_erro),    0);
      verifica({nome, " cc"},      int'(e1_cc),      0);
      verifica({nome, " ca"},      int'(e1_ca),      0);
      verifica({nome, " cn"},      int'(e1_cn),      0);
      verifica({nome, " w2 estado"}, int'(e2_estado), 0);
      verifica({nome, " w2 cn"},     int'(e2_cn),     0);
   endtask

   initial begin
      reset = 1'b0;
      ok    = 1'b0;
      nota  = 5'd0;
      mod1  = zera();
      mod2  = zera();
      repeat (3) @(negedge clock);
      verifica_reset("reset");
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Empty sentence, repeated end, invalid code inside FIM
      strobe(0, 4, -1, "vazia");
      strobe(1, 4, -1, "fim_rep");
      strobe(3, 4, -1, "inval_fim");
      // First noun, then 7,9,9,10,0
      strobe(7, 4, -1, "s1_7");
      strobe(9, 4, -1, "s1_9a");
      strobe(9, 4, -1, "s1_9b");
      strobe(10, 4, -1, "s1_10");
      strobe(0, 4, -1, "s1_fim");
      // Tie between abstrato and nomep, then new sentence
      strobe(9, 4, -1, "s2_9");
      strobe(10, 4, -1, "s2_10");
      strobe(1, 4, -1, "s2_fim");
      strobe(7, 4, -1, "s3_7");
      // Invalid code mid-sentence, then long hold with nota changing under ok
      strobe(3, 4, -1, "inval");
      strobe(7, 20, 9, "hold");
      // Saturation on the 2-bit instance
      for (int i = 0; i < 5; i++)
         strobe(10, 4, -1, $sformatf("sat%0d", i));

      // Asynchronous reset mid-sentence, checked before any clock edge
      @(negedge clock);
      reset = 1'b0;
      #1;
      verifica_reset("reset_async");
      mod1 = zera();
      mod2 = zera();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      strobe(9, 4, -1, "pos_reset");

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/classificador_substantivos.md
# classificador_substantivos

Parametrised successor to the single-word noun classifier. Classifies a stream of noun codes `nota`, each strobed by the asynchronous `ok` key, into concrete, abstract and proper nouns, and keeps saturating per-class counts. When an end code arrives it closes the sentence and reports the majority class. It sits between the keypad/switch front end and the display decoder.

## Interface
Parameters:
- `NOTA_W`, 5, width of the input code
- `CONT_W`, 8, width of each class counter
- `COD_CONCRETO`, 7, code for a concrete noun
- `COD_ABSTRATO`, 9, code for an abstract noun
- `COD_NOMEP`, 10, code for a proper noun
- `COD_FIM0`, 0, end-of-sentence code A
- `COD_FIM1`, 1, end-of-sentence code B

Ports:
- `clock`, in, 1, single system clock
- `reset`, in, 1, asynchronous, active-low
- `ok`, in, 1, asynchronous confirm key; rising edge means "`nota` valid"
- `nota`, in, NOTA_W, noun code; static around `ok` rising edge
- `estado`, out, 3, current FSM state (encoding in package)
- `tipo`, out, 2, class of last accepted noun: 00 none, 01 concreto, 10 abstrato, 11 nomep
- `fim`, out, 1, high while in FIM
- `maioria`, out, 2, majority class of closed sentence, same encoding as `tipo`; 00 outside FIM
- `erro`, out, 1, one-cycle pulse on an unrecognised code
- `cont_concreto`, `cont_abstrato`, `cont_nomep`, out, CONT_W each, per-class counts of current/closed sentence

## Operation
- `ok` passes through a 2-flop synchroniser and a rising-edge detector, producing a one-clock pulse `ok_p`. All state changes happen only on cycles with `ok_p`=1.
- `nota` is sampled on the `ok_p` cycle and decoded to one of: CONCRETO, ABSTRATO, NOMEP, FIM (COD_FIM0 or COD_FIM1), or INVALIDO (any other value).
- States: INICIO, CONCRETO, ABSTRATO, NOMEP, FIM.
- Transitions from INICIO, CONCRETO, ABSTRATO or NOMEP:
  - noun code → matching class state; increment that counter; `tipo` ← class.
  - end code → FIM; latch `maioria`.
  - invalid code → stay in state; pulse `erro`; counters unchanged.
- Transitions from FIM:
  - noun code → clear all counters, then enter the class state with its counter = 1 (new sentence).
  - end code → stay in FIM; no change.
  - invalid code → stay in FIM; pulse `erro`.
- Counters saturate at 2^CONT_W−1; they never wrap.
- `maioria` is the class with the largest count. Ties resolve with priority nomep > abstrato > concreto. All counts zero gives 00.
- End code in INICIO (empty sentence): go to FIM with `maioria`=00 and `tipo`=00.
- `tipo` holds through FIM until the next accepted noun.

## Timing
- Reset (asynchronous assert, synchronous-release assumed upstream) forces: `estado`=INICIO, `tipo`=00, `fim`=0, `maioria`=00, `erro`=0, all counters 0, synchroniser flops 0.
- Latency: rising `ok` → `ok_p` after 2–3 clocks. The state, counters, `tipo`, `fim`, `maioria` and `erro` outputs are registered and update on the clock edge ending the `ok_p` cycle.
- `ok` held high produces exactly one `ok_p`. A new strobe needs `ok` low for at least 2 clocks.
- Reset mid-sentence discards all counts. Any `ok` edge in flight through the synchroniser is lost.
- `nota` changing while `ok` is high is ignored; only the sample at `ok_p` matters.

## Structure
- Package `substantivo_pkg` holds:
  - state enum `estado_t` (3-bit)
  - class enum `tipo_t` (2-bit: NENHUM, CONCRETO, ABSTRATO, NOMEP)
  - default code constants
  - the decode-class enum including FIM and INVALIDO
- Sub-module `sincroniza_borda` implements the 2-flop synchroniser plus rising-edge pulse. It is reusable by other key inputs.
- The top module contains the decode, FSM, counters and majority compare.

## Test plan
- Reset, then `ok` with nota=7 → estado=CONCRETO, tipo=01, cont_concreto=1, fim=0.
- Sequence 7,9,9,10,0 → FIM, fim=1, counts 1/2/1, maioria=10, tipo=11.
- Sequence 9,10,1 (tie) → maioria=11; then nota=7 → counters 1/0/0, estado=CONCRETO, fim=0.
- nota=3 in CONCRETO → erro high exactly one cycle, state and counts unchanged; `ok` held high 20 clocks yields one count only.
- CONT_W=2, nota=10 ×5 → cont_nomep=3 (saturated). Then reset asserted mid-sentence → all outputs return to reset values immediately, without a clock.
